jk_excitation_driver: RTL
=========================

# jk_excitation_driver

Drives J/K inputs of an external WIDTH-bit bank of JK flip-flops so that the bank reaches a requested target word. Accepts a target over a valid/ready handshake, derives per-bit J/K from the JK excitation table against the bank's current Q, pulses J/K for exactly one clock, then checks the bank's Q against the target and reports done/error. It sits between a sequencing controller and the JK register bank.

## Interface
Parameters:
- WIDTH, 4, number of JK bits driven and checked.
- TOGGLE_PREF, 0, 0: the unused excitation input is driven 0; 1: it is driven 1, so changing bits use the J=K=1 toggle.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low.
- tgt_valid  input  1  target word offered.
- tgt_data  input  WIDTH  requested bank state.
- tgt_ready  output  1  block can accept a target.
- q  input  WIDTH  current Q of the external JK bank, sampled on clk.
- j  output  WIDTH  J drive to the bank.
- k  output  WIDTH  K drive to the bank.
- done  output  1  one-cycle pulse when a transfer completes.
- err  output  1  one-cycle pulse, coincident with done, when the bank Q differs from the target.
- err_cnt  output  8  count of err pulses, saturating at 255.

## Operation
- Reset state while reset=0, asynchronous:
  - FSM in IDLE.
  - j=0, k=0, done=0, err=0, err_cnt=0.
  - tgt_ready=1 once reset deasserts.
- FSM states IDLE, DRIVE, CHECK:
  - IDLE: tgt_ready=1. On a rising edge with tgt_valid=1, latch tgt_data into tgt_r, register j/k from the excitation rule using tgt_data and the current q, and go to DRIVE.
  - DRIVE: j/k hold their registered values for exactly this one cycle. tgt_ready=0. Next state is CHECK.
  - CHECK: j=k=0 and tgt_ready=0. On the closing edge, register done=1 and err=(q!=tgt_r); if err, increment err_cnt unless it is 255. Next state is IDLE.
- Excitation rule per bit i (current q[i] -> target t[i]):
  - 0->0: J=0, K=0.
  - 0->1: J=1, K=TOGGLE_PREF.
  - 1->0: J=TOGGLE_PREF, K=1.
  - 1->1: J=0, K=0.
- Outside DRIVE, j=k=0, which holds the bank.
- A target equal to the current q still runs the full IDLE/DRIVE/CHECK sequence with j=k=0 and completes with done=1, err=0.
- tgt_valid outside IDLE is ignored. The offering side holds tgt_data until it sees tgt_ready=1.

## Timing
- Acceptance edge E0 -> j/k valid in the cycle after E0 -> bank updates at E1 -> compare during the cycle after E1 -> done/err registered at E2, high for the single cycle after E2.
- The cycle after E2 is also IDLE, so tgt_ready=1 and a new target can be accepted at E3.
- Throughput: one target per 3 cycles. done rises 2 edges after acceptance.
- reset asserted mid-transfer: immediately j=k=0, no done/err pulse, err_cnt=0, FSM returns to IDLE.
- err_cnt saturates at 255. While it is at 255, err pulses still occur.

## Structure
- Shared package jk_pkg:
  - state enum (IDLE, DRIVE, CHECK).
  - the four excitation localparams expressed as {J,K} pairs.
- Sub-module jk_excite_bit: combinational, one instance per bit via generate.
  - inputs: q_bit, t_bit, toggle_pref.
  - outputs: j_bit, k_bit.
- Top level: FSM, tgt_r register, j/k output registers, err_cnt.

## Test plan
The bench supplies the JK bank model. All cases use WIDTH=4 and the defaults unless stated.
- Reset, then q=0000, target 1010 -> in the DRIVE cycle j=1010, k=0000; bank reaches 1010; done=1, err=0 two edges after acceptance.
- q=1010, target 0110, TOGGLE_PREF=1 -> j=1100, k=1100; bank toggles to 0110; done=1, err=0.
- q=0101, target 0101 -> j=k=0000; done=1, err=0, q unchanged.
- Bank bit 0 stuck at 0, target 0001 -> done=1, err=1, err_cnt=1. After 256 such transfers, err_cnt=255.
- reset pulsed low during DRIVE -> j=k=0 immediately, no done pulse, tgt_ready=1 after release, and the next target completes normally.
- tgt_valid held high continuously for three targets -> one accepted per 3 cycles, tgt_ready low in DRIVE and CHECK, each target completes with done in order.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared types and constants for the JK excitation driver.
// Holds the FSM state encoding and the {J,K} excitation pairs.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    // {J,K} pairs for each current->target transition
    localparam logic [1:0] EXC_HOLD0 = 2'b00;
    localparam logic [1:0] EXC_SET   = 2'b10;
    localparam logic [1:0] EXC_RESET = 2'b01;
    localparam logic [1:0] EXC_HOLD1 = 2'b00;
    localparam logic [1:0] EXC_TOG   = 2'b11;

endpackage

// File: rtl/jk_excite_bit.sv
// Per-bit JK excitation: picks J/K that move q_bit to t_bit.
// toggle_pref fills the don't-care input with 1 so changes use J=K=1.
module jk_excite_bit
    import jk_pkg::*;
(
    input  logic q_bit,
    input  logic t_bit,
    input  logic toggle_pref,
    output logic j_bit,
    output logic k_bit
);

    logic [1:0] w_jk;

    // excitation table lookup on {current, target}
    always_comb begin
        w_jk = EXC_HOLD0;
        unique case ({q_bit, t_bit})
            2'b00: w_jk = EXC_HOLD0;
            2'b01: w_jk = toggle_pref ? EXC_TOG : EXC_SET;
            2'b10: w_jk = toggle_pref ? EXC_TOG : EXC_RESET;
            2'b11: w_jk = EXC_HOLD1;
            default: w_jk = EXC_HOLD0;
        endcase
    end

    assign j_bit = w_jk[1];
    assign k_bit = w_jk[0];

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives an external JK bank to a requested word for one clock,
// then checks the bank Q against the target and reports done/err.
module jk_excitation_driver
    import jk_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter bit TOGGLE_PREF = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             done,
    output logic             err,
    output logic [7:0]       err_cnt
);

    state_t           r_state;
    logic [WIDTH-1:0] r_tgt;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic             r_done;
    logic             r_err;
    logic [7:0]       r_err_cnt;

    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             w_miss;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            jk_excite_bit u_bit (
                .q_bit       (q[gi]),
                .t_bit       (tgt_data[gi]),
                .toggle_pref (TOGGLE_PREF),
                .j_bit       (w_j[gi]),
                .k_bit       (w_k[gi])
            );
        end
    endgenerate

    assign w_miss = (q != r_tgt);

    // sequencer: accept, pulse J/K for one cycle, then verify the bank
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_tgt     <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            r_j    <= '0;
            r_k    <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (tgt_valid) begin
                        r_tgt   <= tgt_data;
                        r_j     <= w_j;
                        r_k     <= w_k;
                        r_state <= DRIVE;
                    end
                end
                DRIVE: begin
                    r_state <= CHECK;
                end
                CHECK: begin
                    r_done <= 1'b1;
                    r_err  <= w_miss;
                    if (w_miss && (r_err_cnt != 8'hFF)) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tgt_ready = (r_state == IDLE);
    assign j         = r_j;
    assign k         = r_k;
    assign done      = r_done;
    assign err       = r_err;
    assign err_cnt   = r_err_cnt;

endmodule
